radix4_seq_mult: RTL and testbench

RADIX4_SEQ_MULT -- requirements
Module: radix4_seq_mult

---
 rtl/radix4_seq_mult_pkg.sv | 21 ++
 rtl/radix4_seq_mult_gen_product.sv | 48 ++++
 rtl/radix4_seq_mult.sv | 118 +++++++++++
 tb/tb_radix4_seq_mult.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/radix4_seq_mult_pkg.sv
// rtl/radix4_seq_mult_pkg.sv - shared types and helpers for the radix-4 sequential multiplier
//
// Purpose : FSM state encoding and the Booth digit-count helper shared by the
//           multiplier top and its testbench.
// Contents: state_t    - IDLE / BUSY / DONE
//           num_digits - number of radix-4 Booth digits for a given operand width
package radix4_seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // An unsigned WIDTH-bit multiplier is zero-extended by two bits so the top
  // Booth digit is never negative; that gives WIDTH/2+1 digits.
  function automatic int num_digits(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/radix4_seq_mult_gen_product.sv
// rtl/radix4_seq_mult_gen_product.sv - radix-4 Booth partial-product generator
//
// Purpose : Decode one 3-bit Booth code into a 0 / 1x / 2x multiple of the
//           multiplicand, one's-complemented for negative digits.
// Ports   : booth_code   [2:0]     - {m[2i+1], m[2i], m[2i-1]}
//           multiplicand [WIDTH-1:0]
//           partial_prod [WIDTH:0] - magnitude, inverted when sign=1
//           sign                   - digit is negative; the caller adds it back
//                                    as the +1 of the two's complement
module gen_product #(
  parameter int WIDTH = 16
) (
  input  logic [2:0]       booth_code,
  input  logic [WIDTH-1:0] multiplicand,
  output logic [WIDTH:0]   partial_prod,
  output logic             sign
);

  logic [WIDTH:0] magnitude;
  logic           neg;

  always_comb begin
    magnitude = '0;
    neg       = 1'b0;
    unique case (booth_code)
      3'b001, 3'b010: magnitude = {1'b0, multiplicand};
      3'b011:         magnitude = {multiplicand, 1'b0};
      3'b100: begin
        magnitude = {multiplicand, 1'b0};
        neg       = 1'b1;
      end
      3'b101, 3'b110: begin
        magnitude = {1'b0, multiplicand};
        neg       = 1'b1;
      end
      // 000 and 111 are both a zero digit; 111 is treated as +0 so it never
      // produces an all-ones word plus carry.
      default: begin
        magnitude = '0;
        neg       = 1'b0;
      end
    endcase
  end

  assign partial_prod = neg ? ~magnitude : magnitude;
  assign sign         = neg;

endmodule

// File: rtl/radix4_seq_mult.sv
// rtl/radix4_seq_mult.sv - unsigned radix-4 Booth sequential multiplier
//
// Purpose : Multiplies two unsigned WIDTH-bit operands, one Booth digit per
//           clock, with a valid/ready handshake on both sides. Fixed latency
//           of NUM_DIGITS edges from acceptance to valid_o.
// Ports   : clk_i, rst_ni                - clock, async active-low reset
//           valid_i, ready_o             - operand handshake
//           multiplicand_i, multiplier_i - unsigned operands, WIDTH bits
//           valid_o, ready_i             - product handshake
//           product_o                    - exact product, 2*WIDTH bits
module radix4_seq_mult
  import radix4_seq_mult_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [WIDTH-1:0]     multiplicand_i,
  input  logic [WIDTH-1:0]     multiplier_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [2*WIDTH-1:0]   product_o
);

  localparam int NUM_DIGITS = num_digits(WIDTH);
  localparam int CNT_W      = $clog2(NUM_DIGITS);
  localparam int ACC_W      = 2 * WIDTH + 2;
  localparam int MPX_W      = WIDTH + 3;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NUM_DIGITS - 1);

  state_t             state_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH+1:0]   mplier_q;
  logic [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [MPX_W-1:0]   mplier_ext;
  logic [2:0]         booth_code;
  logic [WIDTH:0]     pp_word;
  logic               pp_sign;
  logic [ACC_W-1:0]   pp_ext;
  logic [ACC_W-1:0]   addend;

  // Appending m[-1]=0 below bit 0 turns digit i's code into a plain 3-bit
  // slice starting at bit 2i.
  assign mplier_ext = {mplier_q, 1'b0};
  assign booth_code = mplier_ext[{cnt_q, 1'b0} +: 3];

  gen_product #(
    .WIDTH (WIDTH)
  ) u_gen_product (
    .booth_code   (booth_code),
    .multiplicand (mcand_q),
    .partial_prod (pp_word),
    .sign         (pp_sign)
  );

  // Sign-extend the one's-complement word and add the sign bit to complete
  // the two's complement, then weight by 4^i.
  assign pp_ext = {{(ACC_W - WIDTH - 2){pp_sign}}, pp_sign, pp_word};
  assign addend = (pp_ext + ACC_W'(pp_sign)) << {cnt_q, 1'b0};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      ready_o  <= 1'b1;
      valid_o  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (valid_i) begin
            mcand_q  <= multiplicand_i;
            mplier_q <= {2'b00, multiplier_i};
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= BUSY;
            ready_o  <= 1'b0;
          end
        end
        BUSY: begin
          acc_q <= acc_q + addend;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_DIGIT) begin
            state_q <= DONE;
            valid_o <= 1'b1;
          end
        end
        DONE: begin
          // ready_o only rises after this edge, so ready_i never reaches
          // ready_o combinationally.
          if (ready_i) begin
            state_q <= IDLE;
            valid_o <= 1'b0;
            ready_o <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_o <= 1'b1;
          valid_o <= 1'b0;
        end
      endcase
    end
  end

  assign product_o = acc_q[2*WIDTH-1:0];

  // The two guard bits only absorb intermediate carries/borrows.
  logic unused_acc_guard;
  assign unused_acc_guard = ^acc_q[ACC_W-1:2*WIDTH];

endmodule

// File: tb/tb_radix4_seq_mult.sv
// tb/tb_radix4_seq_mult.sv - scoreboard testbench for radix4_seq_mult
module tb_radix4_seq_mult;

  localparam int W = 16;

  logic             clk_i;
  logic             rst_ni;
  logic             valid_i;
  logic             ready_o;
  logic [W-1:0]     multiplicand_i;
  logic [W-1:0]     multiplier_i;
  logic             valid_o;
  logic             ready_i;
  logic [2*W-1:0]   product_o;

  radix4_seq_mult #(.WIDTH(W)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .multiplicand_i (multiplicand_i),
    .multiplier_i   (multiplier_i),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .product_o      (product_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;
  int pushes = 0;
  int pops   = 0;
  logic [2*W-1:0] sb[$];
  bit rand_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a product is consumed when valid_o && ready_i at the next edge.
  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_ni && valid_o && ready_i) begin
        if (sb.size() == 0) begin
          check("unexpected_product", {32'd0, product_o}, 64'hDEAD_BEEF_DEAD_BEEF);
        end else begin
          logic [2*W-1:0] e;
          e = sb.pop_front();
          pops++;
          check("product", {32'd0, product_o}, {32'd0, e});
        end
      end
      if (rst_ni && valid_o && ready_o) check("ready_valid_overlap", 64'd1, 64'd0);
    end
  end

  // Random backpressure when enabled.
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      if (rand_ready) ready_i = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Offers an operand pair; returns 1 time unit after the acceptance edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    int k;
    logic [2*W-1:0] e;
    valid_i        = 1'b1;
    multiplicand_i = a;
    multiplier_i   = b;
    k = 0;
    @(negedge clk_i);
    while (!ready_o && k < 200) begin
      @(negedge clk_i);
      k++;
    end
    if (!ready_o) begin
      check("accept_timeout", 64'd0, 64'd1);
      valid_i = 1'b0;
    end else begin
      e = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      sb.push_back(e);
      pushes++;
      @(posedge clk_i);
      #1;
      valid_i = 1'b0;
      // Scribble on the operand bus while busy; the block must ignore it.
      multiplicand_i = W'($urandom);
      multiplier_i   = W'($urandom);
    end
  endtask

  task automatic timed_op(input logic [W-1:0] a, input logic [W-1:0] b, input string name);
    int n;
    issue(a, b);
    n = 0;
    while (n < 30) begin
      @(posedge clk_i);
      n++;
      #1;
      if (valid_o) break;
    end
    check(name, 64'(n), 64'd9);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (!ready_o && k < 200) begin
      @(posedge clk_i);
      #1;
      k++;
    end
    check("drain_to_idle", {63'd0, ready_o}, 64'd1);
  endtask

  initial begin
    logic [2*W-1:0] held;
    rst_ni         = 1'b0;
    valid_i        = 1'b0;
    ready_i        = 1'b0;
    multiplicand_i = '0;
    multiplier_i   = '0;
    #12;
    check("reset_ready", {63'd0, ready_o}, 64'd1);
    check("reset_valid", {63'd0, valid_o}, 64'd0);
    check("reset_product", {32'd0, product_o}, 64'd0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // 3x5 with downstream stalled: latency, then hold in DONE for 5 cycles.
    timed_op(16'd3, 16'd5, "latency_3x5");
    held = product_o;
    check("done_product_3x5", {32'd0, product_o}, 64'h0000_000F);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i);
      #1;
      check("hold_valid", {63'd0, valid_o}, 64'd1);
      check("hold_product", {32'd0, product_o}, {32'd0, held});
      check("hold_ready_low", {63'd0, ready_o}, 64'd0);
    end
    ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("release_ready", {63'd0, ready_o}, 64'd1);
    check("release_valid", {63'd0, valid_o}, 64'd0);

    // Boundary operands with the downstream always ready.
    timed_op(16'hFFFF, 16'hFFFF, "latency_ffff");
    wait_idle();
    timed_op(16'h8000, 16'h0002, "latency_8000x2");
    wait_idle();
    timed_op(16'h1234, 16'h0000, "latency_zero_b");
    wait_idle();
    timed_op(16'h0000, 16'hABCD, "latency_zero_a");
    wait_idle();

    // Reset after 4 BUSY edges: operation is abandoned.
    ready_i = 1'b0;
    issue(16'h1234, 16'h5678);
    repeat (4) @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    sb.delete();
    pushes = pops;
    #1;
    check("midreset_ready", {63'd0, ready_o}, 64'd1);
    check("midreset_valid", {63'd0, valid_o}, 64'd0);
    check("midreset_product", {32'd0, product_o}, 64'd0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    ready_i = 1'b1;
    timed_op(16'd7, 16'd9, "latency_7x9");
    check("product_7x9", {32'd0, product_o}, 64'h0000_003F);
    wait_idle();

    // Random back-to-back traffic with random backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 250; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      case ($urandom_range(0, 7))
        0:       a = '0;
        1:       a = '1;
        default: a = W'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0:       b = '0;
        1:       b = '1;
        default: b = W'($urandom);
      endcase
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk_i);
        #1;
      end
      issue(a, b);
    end
    rand_ready = 1'b0;
    ready_i    = 1'b1;
    begin
      int k;
      k = 0;
      while (sb.size() != 0 && k < 500) begin
        @(posedge clk_i);
        k++;
      end
    end
    @(posedge clk_i);
    #1;
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    check("pops_equal_pushes", 64'(pops), 64'(pushes));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
